// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- HI/LO register file and sequencer for a multi-cycle signed divider
//
// Accepts EX-stage requests (DIV, MTHI, MTLO), launches an external divider,
// stalls the pipeline while the divide is in flight and captures the
// quotient/remainder into LO/HI.
//
// Ports:
//   clock         in   1   sole clock, rising edge
//   reset         in   1   synchronous, active-low
//   op            in   2   00 none, 01 DIV (signed), 10 MTHI, 11 MTLO
//   rs_data       in  32   dividend / MTHI / MTLO source
//   rt_data       in  32   divisor
//   stall         out  1   pipeline hold while a divide is in flight
//   hi            out 32   HI register (remainder or MTHI value)
//   lo            out 32   LO register (quotient or MTLO value)
//   div_start     out  1   one-cycle launch pulse to the divider
//   div_dividend  out 32   dividend to the divider (held from LAUNCH to DONE)
//   div_divisor   out 32   divisor to the divider (held from LAUNCH to DONE)
//   div_busy      in   1   divider busy flag
//   div_q         in  32   divider quotient
//   div_r         in  32   divider remainder
//   div_zero      out  1   divide-by-zero flag (one-cycle pulse when trapping)
//   dbg_state     out  2   current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT, 3 DONE)
//
// Build option:
//   DIV_ZERO_TRAP_EN  when defined, a DIV with rt_data == 0 is not launched;
//                     instead div_zero pulses for one cycle. When undefined,
//                     div_zero is tied 0 and zero divisors launch normally.
//
// Handshake: the divider is launched by a single div_start pulse; a divide is
// considered complete only once div_busy has been observed high and has then
// returned low, so a divider that needs a cycle to raise busy is tolerated.
// -----------------------------------------------------------------------------
module mdu_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        div_zero,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        seen_busy_q, seen_busy_d;

  logic        is_div;
  logic        zero_trap;
  logic        wait_exit;

  assign is_div    = (op == OP_DIV);
  assign wait_exit = seen_busy_q && !div_busy;

`ifdef DIV_ZERO_TRAP_EN
  // A zero divisor is intercepted in IDLE regardless of divider state.
  assign zero_trap = (rt_data == 32'd0);
`else
  assign zero_trap = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      dividend_q  <= 32'd0;
      divisor_q   <= 32'd0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (is_div && !div_busy && !zero_trap) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (wait_exit) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;   // op here belongs to the finished DIV
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: operand latch, HI/LO writes, seen_busy tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    seen_busy_d = seen_busy_q;
    case (state_q)
      S_IDLE: begin
        case (op)
          OP_DIV: begin
            if (!div_busy && !zero_trap) begin
              dividend_d = rs_data;
              divisor_d  = rt_data;
            end
          end
          OP_MTHI: hi_d = rs_data;
          OP_MTLO: lo_d = rs_data;
          default: ;
        endcase
      end
      S_WAIT: begin
        if (wait_exit) begin
          lo_d        = div_q;
          hi_d        = div_r;
          seen_busy_d = 1'b0;
        end else if (div_busy) begin
          seen_busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stall     = 1'b0;
    div_start = 1'b0;
    case (state_q)
      S_IDLE:   stall = is_div && !zero_trap;
      S_LAUNCH: begin
        stall     = 1'b1;
        div_start = 1'b1;
      end
      S_WAIT:   stall = 1'b1;
      default:  ;
    endcase
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign dbg_state    = state_q;

`ifdef DIV_ZERO_TRAP_EN
  logic div_zero_q, div_zero_d;

  always_comb begin
    div_zero_d = (state_q == S_IDLE) && is_div && zero_trap;
  end

  always_ff @(posedge clock) begin
    if (!reset) div_zero_q <= 1'b0;
    else        div_zero_q <= div_zero_d;
  end

  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-low reset.
REQ-003 SHALL have port: op  in  2  EX-stage request: 00 none, 01 DIV (signed), 10 MTHI, 11 MTLO.
REQ-004 SHALL have port: rs_data  in  32  dividend / MTHI / MTLO source.
REQ-005 SHALL have port: rt_data  in  32  divisor.
REQ-006 SHALL have port: stall  out  1  holds the pipeline while a divide is in flight.
REQ-007 SHALL have port: hi  out  32  HI register, remainder or MTHI value.
REQ-008 SHALL have port: lo  out  32  LO register, quotient or MTLO value.
REQ-009 SHALL have port: div_start  out  1  one-cycle launch pulse to the downstream divider.
REQ-010 SHALL have port: div_dividend  out  32  dividend to the divider.
REQ-011 SHALL have port: div_divisor  out  32  divisor to the divider.
REQ-012 SHALL have port: div_busy  in  1  divider busy flag.
REQ-013 SHALL have port: div_q  in  32  divider quotient.
REQ-014 SHALL have port: div_r  in  32  divider remainder.
REQ-015 SHALL have port: div_zero  out  1  divide-by-zero flag, see Configuration.

Function
REQ-016 SHALL implement FSM IDLE, LAUNCH, WAIT, DONE.
REQ-017 IDLE, op=DIV, div_busy=0: SHALL latch rs_data/rt_data into operand registers and go to LAUNCH.
REQ-018 IDLE, op=DIV, div_busy=1: SHALL remain in IDLE with stall=1 until div_busy=0.
REQ-019 stall SHALL be combinational: 1 in IDLE when op=DIV, 1 in LAUNCH and WAIT, 0 in DONE.
REQ-020 LAUNCH SHALL drive div_start=1 for exactly one cycle, then go to WAIT; div_start SHALL be 0 in all other states.
REQ-021 div_dividend/div_divisor SHALL drive the operand registers, held stable from LAUNCH until the DONE exit, because the divider's q/r depend on its operand inputs combinationally.
REQ-022 WAIT SHALL set a seen_busy flag when div_busy=1, and SHALL exit only when seen_busy=1 and div_busy=0.
REQ-023 On WAIT exit: lo<=div_q, hi<=div_r, go to DONE, clear seen_busy.
REQ-024 DONE SHALL ignore op, since it carries the completed DIV, and SHALL return to IDLE next cycle.
REQ-025 Latency with a 32-cycle divider: request at T0, div_start at T1, busy T2-T33, capture at end of T34, DONE at T35 with new hi/lo visible; stall=1 for T0-T34.
REQ-026 In IDLE only, op=MTHI SHALL set hi<=rs_data and op=MTLO SHALL set lo<=rs_data at the next edge, with no stall; lo/hi respectively unchanged.
REQ-027 In states other than IDLE, op SHALL be ignored except as stated.
REQ-028 hi/lo SHALL change only per REQ-023, REQ-026 or reset.

Reset
REQ-029 reset=0 at an edge SHALL force state IDLE, hi=0, lo=0, operand registers 0, seen_busy=0, div_zero=0; stall and div_start SHALL then be 0 unless REQ-019 applies.
REQ-030 Reset mid-divide SHALL abandon the operation with no hi/lo write.
REQ-031 If the divider is not also reset, REQ-018 SHALL govern the next DIV.

Configuration
REQ-032 Macro DIV_ZERO_TRAP_EN defined: IDLE with op=DIV and rt_data=0 SHALL NOT stall or launch, SHALL leave hi/lo unchanged, and SHALL register div_zero=1 for exactly the following cycle.
REQ-033 Macro DIV_ZERO_TRAP_EN undefined: div_zero SHALL be constant 0, and zero divisors SHALL launch normally with the divider's outputs captured.

Verification
REQ-034 SHALL cover: DIV rs=100, rt=7 -> stall high 35 cycles, one div_start pulse at T1, lo=14, hi=2 at T35.
REQ-035 SHALL cover: DIV rs=0xFFFFFFF9, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 SHALL cover: MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi/lo updated one edge after each, stall never high.
REQ-037 SHALL cover: reset=0 at T10 of a divide -> next cycle IDLE, stall=0, hi=lo=0; a following DIV 9/3 with the divider busy waits, then gives lo=3, hi=0.
REQ-038 SHALL cover, with DIV_ZERO_TRAP_EN: DIV rs=5, rt=0 -> div_zero one-cycle pulse, stall=0, no div_start, hi/lo unchanged.
REQ-039 SHALL cover, without DIV_ZERO_TRAP_EN: DIV rs=5, rt=0 -> div_zero stays 0, divide launches normally.
